// File: rtl/alsu_ctrl_pkg.sv
// Shared constants for the ALSU arbiter controller: command layout, opcodes,
// the NOP drive encoding, arbiter state encoding and the in-flight tag record.
package alsu_ctrl_pkg;

   localparam int CMD_W     = 16;
   localparam int OP_LSB    = 13;
   localparam int A_LSB     = 10;
   localparam int B_LSB     = 7;
   localparam int CIN_BIT   = 6;
   localparam int SIN_BIT   = 5;
   localparam int DIR_BIT   = 4;
   localparam int RED_A_BIT = 3;
   localparam int RED_B_BIT = 2;
   localparam int BYP_A_BIT = 1;
   localparam int BYP_B_BIT = 0;

   localparam logic [2:0] OP_AND   = 3'b000;
   localparam logic [2:0] OP_XOR   = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_MULT  = 3'b011;
   localparam logic [2:0] OP_SHIFT = 3'b100;
   localparam logic [2:0] OP_ROT   = 3'b101;
   localparam logic [2:0] OP_INV0  = 3'b110;
   localparam logic [2:0] OP_INV1  = 3'b111;

   // Bypass A with A=0: the ALSU produces 0, which also clears the shift history.
   localparam logic [CMD_W-1:0] NOP_CMD = 16'(1 << BYP_A_BIT);

   localparam logic [0:0] ST_UNLOCKED = 1'b0;
   localparam logic [0:0] ST_LOCKED   = 1'b1;

   typedef struct packed {
      logic       valid;
      logic [2:0] id;
      logic       err;
   } tag_t;

   function automatic logic cmd_is_err(input logic [CMD_W-1:0] cmd);
      return (cmd[OP_LSB +: 3] == OP_INV0) || (cmd[OP_LSB +: 3] == OP_INV1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first eligible requester at or after the pointer, wrapping.
module rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  lock_mask,
   input  logic [PTR_W-1:0] pointer,
   output logic [NREQ-1:0]  grant
);

   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] grant_hi;
   logic [NREQ-1:0] grant_lo;
   logic            hit_hi;
   logic            hit_lo;

   assign eligible = req & lock_mask;

   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
      grant_hi = '0;
      grant_lo = '0;
      hit_hi   = 1'b0;
      hit_lo   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (eligible[i] && (i >= int'(pointer)) && !hit_hi) begin
            grant_hi[i] = 1'b1;
            hit_hi      = 1'b1;
         end
         if (eligible[i] && !hit_lo) begin
            grant_lo[i] = 1'b1;
            hit_lo      = 1'b1;
         end
      end
      grant = hit_hi ? grant_hi : grant_lo;
   end

endmodule

// File: rtl/alsu_arbiter_ctrl.sv
// Arbitrates NREQ requesters onto one pipelined ALSU, with optional owner lock,
// and returns each result tagged with its requester id LATENCY cycles after accept.
module alsu_arbiter_ctrl #(
   parameter int NREQ         = 2,
   parameter int LATENCY      = 4,
   parameter int LOCK_TIMEOUT = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ-1:0]     req_lock,
   input  logic [16*NREQ-1:0]  req_cmd,
   output logic                rsp_valid,
   output logic [2:0]          rsp_id,
   output logic [5:0]          rsp_data,
   output logic                rsp_err,
   output logic [2:0]          alsu_a,
   output logic [2:0]          alsu_b,
   output logic [2:0]          alsu_opcode,
   output logic                alsu_cin,
   output logic                alsu_serial_in,
   output logic                alsu_direction,
   output logic                alsu_red_op_a,
   output logic                alsu_red_op_b,
   output logic                alsu_bypass_a,
   output logic                alsu_bypass_b,
   input  logic [5:0]          alsu_out
);

   import alsu_ctrl_pkg::*;

   localparam int PTR_W = $clog2(NREQ);
   localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);

   logic [0:0]       state_q;
   logic [PTR_W-1:0] owner_q;
   logic [PTR_W-1:0] ptr_q;
   logic [TO_W-1:0]  to_cnt_q;
   logic [NREQ-1:0]  owner_mask;
   logic [NREQ-1:0]  allow_mask;
   logic [NREQ-1:0]  grant;
   logic             accept;
   logic             lock_sel;
   logic             owner_valid;
   logic [PTR_W-1:0] gnt_idx;
   logic [CMD_W-1:0] sel_cmd;
   logic [CMD_W-1:0] cmd_q;
   tag_t             tag_in;
   tag_t             tag_q [LATENCY];

   assign owner_mask  = NREQ'(1) << owner_q;
   assign allow_mask  = (state_q == ST_LOCKED) ? owner_mask : '1;

   rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
      .req       (req_valid),
      .lock_mask (allow_mask),
      .pointer   (ptr_q),
      .grant     (grant)
   );

   assign req_ready   = rst ? '0 : grant;
   assign accept      = |req_ready;
   assign lock_sel    = |(req_lock & req_ready);
   assign owner_valid = |(req_valid & owner_mask);

   always_comb begin
      gnt_idx = '0;
      sel_cmd = NOP_CMD;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            gnt_idx = PTR_W'(i);
            sel_cmd = req_cmd[i*CMD_W +: CMD_W];
         end
      end
   end

   always_comb begin
      tag_in = '0;
      if (accept) begin
         tag_in.valid = 1'b1;
         tag_in.id    = 3'(gnt_idx);
         tag_in.err   = cmd_is_err(sel_cmd);
      end
   end

   // Pointer, lock ownership and the owner-idle timeout.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q  <= ST_UNLOCKED;
         owner_q  <= '0;
         ptr_q    <= '0;
         to_cnt_q <= '0;
      end else begin
         if (accept)
            ptr_q <= (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         if (state_q == ST_LOCKED) begin
            if (accept) begin
               to_cnt_q <= '0;
               if (!lock_sel)
                  state_q <= ST_UNLOCKED;
            end else if (!owner_valid) begin
               if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                  state_q  <= ST_UNLOCKED;
                  to_cnt_q <= '0;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
         end else if (accept && lock_sel) begin
            state_q  <= ST_LOCKED;
            owner_q  <= gnt_idx;
            to_cnt_q <= '0;
         end
      end
   end

   // Issue register and in-flight tag pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q <= NOP_CMD;
         // NOTE: every tag entry is reset so a command accepted before rst can never surface as a response.
         for (int k = 0; k < LATENCY; k++)
            tag_q[k] <= '0;
      end else begin
         cmd_q    <= accept ? sel_cmd : NOP_CMD;
         tag_q[0] <= tag_in;
         for (int k = 1; k < LATENCY; k++)
            tag_q[k] <= tag_q[k-1];
      end
   end

   assign alsu_opcode    = cmd_q[OP_LSB +: 3];
   assign alsu_a         = cmd_q[A_LSB +: 3];
   assign alsu_b         = cmd_q[B_LSB +: 3];
   assign alsu_cin       = cmd_q[CIN_BIT];
   assign alsu_serial_in = cmd_q[SIN_BIT];
   assign alsu_direction = cmd_q[DIR_BIT];
   assign alsu_red_op_a  = cmd_q[RED_A_BIT];
   assign alsu_red_op_b  = cmd_q[RED_B_BIT];
   assign alsu_bypass_a  = cmd_q[BYP_A_BIT];
   assign alsu_bypass_b  = cmd_q[BYP_B_BIT];

   assign rsp_valid = tag_q[LATENCY-1].valid;
   assign rsp_id    = tag_q[LATENCY-1].id;
   assign rsp_err   = tag_q[LATENCY-1].err;
   assign rsp_data  = rsp_valid ? alsu_out : '0;

endmodule

// File: tb/tb_alsu_arbiter_ctrl.sv
// Directed bench for alsu_arbiter_ctrl with a 3-stage ALSU model and a response scoreboard.
module tb_alsu_arbiter_ctrl;

   localparam int NREQ    = 2;
   localparam int LATENCY = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ready;
   logic [NREQ-1:0] req_lock;
   logic [31:0]     req_cmd;
   logic            rsp_valid;
   logic [2:0]      rsp_id;
   logic [5:0]      rsp_data;
   logic            rsp_err;
   logic [2:0]      alsu_a, alsu_b, alsu_opcode;
   logic            alsu_cin, alsu_serial_in, alsu_direction;
   logic            alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b;
   logic [5:0]      alsu_out;

   typedef struct {
      int         id;
      logic [5:0] data;
      logic       err;
      int         due;
   } sb_entry_t;

   sb_entry_t sb[$];
   sb_entry_t mon_e;
   int        cyc     = 0;
   int        n_checks = 0;
   int        n_pass   = 0;
   logic [5:0] s1, s2, s3;

   alsu_arbiter_ctrl #(.NREQ(NREQ), .LATENCY(LATENCY), .LOCK_TIMEOUT(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_lock       (req_lock),
      .req_cmd        (req_cmd),
      .rsp_valid      (rsp_valid),
      .rsp_id         (rsp_id),
      .rsp_data       (rsp_data),
      .rsp_err        (rsp_err),
      .alsu_a         (alsu_a),
      .alsu_b         (alsu_b),
      .alsu_opcode    (alsu_opcode),
      .alsu_cin       (alsu_cin),
      .alsu_serial_in (alsu_serial_in),
      .alsu_direction (alsu_direction),
      .alsu_red_op_a  (alsu_red_op_a),
      .alsu_red_op_b  (alsu_red_op_b),
      .alsu_bypass_a  (alsu_bypass_a),
      .alsu_bypass_b  (alsu_bypass_b),
      .alsu_out       (alsu_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALSU: compute stage plus two delay stages; shift/rotate use the previous compute result.
   function automatic logic [5:0] alsu_model(input logic [2:0] op, a, b,
                                             input logic cin, sin, dir, ra, rb, ba, bb,
                                             input logic [5:0] prev);
      if (ba) return {3'b000, a};
      if (bb) return {3'b000, b};
      case (op)
         3'b000:  return ra ? {5'b0, &a} : rb ? {5'b0, &b} : {3'b000, a & b};
         3'b001:  return ra ? {5'b0, ^a} : rb ? {5'b0, ^b} : {3'b000, a ^ b};
         3'b010:  return 6'(a) + 6'(b) + 6'(cin);
         3'b011:  return 6'(a) * 6'(b);
         3'b100:  return dir ? {prev[4:0], sin} : {sin, prev[5:1]};
         3'b101:  return dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
         default: return 6'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= alsu_model(alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_serial_in, alsu_direction,
                          alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b, s1);
         s2 <= s1;
         s3 <= s2;
      end
   end
   assign alsu_out = s3;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] mk(input logic [2:0] op, a, b, input logic [6:0] ctl);
      return {op, a, b, ctl};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, lk, input logic [15:0] c0, c1);
      req_valid = v;
      req_lock  = lk;
      req_cmd   = {c1, c0};
      #1;
   endtask

   task automatic expect_grant(input string tag, input logic [1:0] exp_ready,
                               input logic [5:0] data, input logic err);
      sb_entry_t e;
      check(tag, req_ready, exp_ready);
      if (exp_ready != 2'b00) begin
         e.id   = exp_ready[1] ? 1 : 0;
         e.data = data;
         e.err  = err;
         e.due  = cyc + LATENCY;
         sb.push_back(e);
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
      check(tag, sb.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(2'b00, 2'b00, 16'h0, 16'h0);
      sb.delete();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_id"},    rsp_id,    0);
      check({tag, "_rsp_data"},  rsp_data,  0);
      check({tag, "_rsp_err"},   rsp_err,   0);
      check({tag, "_nop_a"},     {alsu_opcode, alsu_a, alsu_b}, 0);
      check({tag, "_nop_ctl"},   {alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_a,
                                  alsu_red_op_b, alsu_bypass_a, alsu_bypass_b}, 7'b0000010);
   endtask

   // Response monitor: pops one expectation per rsp_valid and checks the arrival cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", rsp_valid, 0);
            end else begin
               mon_e = sb.pop_front();
               check("rsp_cycle", cyc, mon_e.due);
               check("rsp_id",    rsp_id, mon_e.id);
               check("rsp_data",  rsp_data, mon_e.data);
               check("rsp_err",   rsp_err, mon_e.err);
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("rsp_missing", rsp_valid, 1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] c_add, c_and, c_xor, c_byp, c_shl, c_x12, c_inv, c_and7, c_add11;
      c_add   = mk(3'b010, 3'd3, 3'd5, 7'b1000000);  // 3+5+1 = 9
      c_and   = mk(3'b000, 3'd6, 3'd3, 7'b0000000);  // 6&3 = 2
      c_xor   = mk(3'b001, 3'd5, 3'd3, 7'b0000000);  // 5^3 = 6
      c_byp   = mk(3'b000, 3'd5, 3'd0, 7'b0000010);  // bypass A = 5
      c_shl   = mk(3'b100, 3'd0, 3'd0, 7'b0110000);  // {5[4:0],1} = 11
      c_x12   = mk(3'b001, 3'd1, 3'd2, 7'b0000000);  // 1^2 = 3
      c_inv   = mk(3'b110, 3'd2, 3'd1, 7'b0000000);  // invalid -> 0, err
      c_and7  = mk(3'b000, 3'd7, 3'd7, 7'b0000000);  // 7
      c_add11 = mk(3'b010, 3'd1, 3'd1, 7'b0000000);  // 2

      // Reset state
      rst = 1'b1;
      drive(2'b11, 2'b00, c_add, c_add);
      check("ready_in_rst", req_ready, 2'b00);
      tick();
      rst = 1'b0;
      drive(2'b00, 2'b00, 16'h0, 16'h0);
      check_idle_outputs("reset");
      check("ready_idle", req_ready, 2'b00);

      // Single ADD
      tick(); tick();
      drive(2'b01, 2'b00, c_add, 16'h0);
      expect_grant("t1_ready", 2'b01, 6'd9, 1'b0);
      tick();
      drive(2'b00, 2'b00, 16'h0, 16'h0);
      drain("t1_drain");

      // Contention: req0 then req1 on consecutive cycles
      do_reset();
      drive(2'b11, 2'b00, c_and, c_xor);
      expect_grant("t2_first", 2'b01, 6'd2, 1'b0);
      tick();
      drive(2'b11, 2'b00, c_and, c_xor);
      expect_grant("t2_second", 2'b10, 6'd6, 1'b0);
      tick();
      drive(2'b00, 2'b00, 16'h0, 16'h0);
      drain("t2_drain");

      // Locked shift chain with req1 held valid
      do_reset();
      drive(2'b11, 2'b01, c_byp, c_x12);
      expect_grant("t3_lock", 2'b01, 6'd5, 1'b0);
      tick();
      drive(2'b11, 2'b00, c_shl, c_x12);
      expect_grant("t3_shift", 2'b01, 6'd11, 1'b0);
      tick();
      drive(2'b10, 2'b00, 16'h0, c_x12);
      expect_grant("t3_req1", 2'b10, 6'd3, 1'b0);
      tick();
      drive(2'b00, 2'b00, 16'h0, 16'h0);
      drain("t3_drain");

      // Invalid opcode
      do_reset();
      drive(2'b10, 2'b00, 16'h0, c_inv);
      expect_grant("t4_ready", 2'b10, 6'd0, 1'b1);
      tick();
      drive(2'b00, 2'b00, 16'h0, 16'h0);
      drain("t4_drain");

      // Lock timeout: req1 blocked for 8 owner-idle cycles, granted on the 9th
      do_reset();
      drive(2'b01, 2'b01, c_and7, 16'h0);
      expect_grant("t5_lock", 2'b01, 6'd7, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         drive(2'b10, 2'b00, 16'h0, c_add11);
         check("t5_blocked", req_ready, 2'b00);
      end
      tick();
      drive(2'b10, 2'b00, 16'h0, c_add11);
      expect_grant("t5_release", 2'b10, 6'd2, 1'b0);
      tick();
      drive(2'b00, 2'b00, 16'h0, 16'h0);
      drain("t5_drain");

      // Reset mid-flight discards the in-flight command
      do_reset();
      drive(2'b01, 2'b00, c_add, 16'h0);
      expect_grant("t6_accept", 2'b01, 6'd9, 1'b0);
      tick();
      drive(2'b00, 2'b00, 16'h0, 16'h0);
      tick();
      rst = 1'b1;
      drive(2'b11, 2'b00, c_add, c_add);
      check("t6_ready_in_rst", req_ready, 2'b00);
      sb.delete();
      tick();
      rst = 1'b0;
      drive(2'b00, 2'b00, 16'h0, 16'h0);
      check_idle_outputs("t6_post");
      for (int k = 0; k < 10; k++) begin
         tick();
         check("t6_no_rsp", rsp_valid, 0);
      end

      check("final_sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alsu_arbiter_ctrl.md
Name: alsu_arbiter_ctrl

Overview:
Shares one ALSU datapath between NREQ requesters using a valid/ready command interface and round-robin arbitration. It issues at most one command per cycle on registered ALSU input drives and tracks in-flight commands in a LATENCY-deep tag pipeline. It returns each result with its requester id at a fixed latency. An optional per-command lock lets one requester issue back-to-back shift/rotate chains without interleaving.

Parameters:
NREQ, 2, number of requesters (2..8).
LATENCY, 4, cycles from the acceptance cycle to rsp_valid (1 ctrl register + 3 ALSU stages). Must be >= 2.
LOCK_TIMEOUT, 8, consecutive owner-idle cycles after which a held lock is force-released.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester command valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_lock  in  NREQ  keep grant after this command
req_cmd  in  16*NREQ  packed commands, bits [16i+15:16i] belong to requester i
rsp_valid  out  1  result valid, single-cycle pulse
rsp_id  out  3  requester index of the result
rsp_data  out  6  ALSU result
rsp_err  out  1  command used opcode 110/111
alsu_a, alsu_b, alsu_opcode  out  3 each  ALSU operand/opcode drives
alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b  out  1 each  ALSU control drives
alsu_out  in  6  ALSU result

Behaviour:
- Reset values. rst is sampled on posedge clk only; no async path.
  - While rst=1: req_ready=0.
  - After reset: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - Tag pipeline is cleared, RR pointer=0, lock released, timeout counter=0.
  - ALSU drives are set to NOP.
- Command fields: [15:13] opcode, [12:10] A, [9:7] B, [6] cin, [5] serial_in, [4] direction, [3] red_op_A, [2] red_op_B, [1] bypass_A, [0] bypass_B.
- NOP: bypass_a=1, a=0, all other drives 0. The ALSU result for a NOP is 0.
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both 1. req_ready is combinational from req_valid, the RR pointer and the lock state.
- Arbitration when unlocked:
  - Grant the first valid requester at or after the pointer, wrapping.
  - After each accept, pointer = granted index + 1, modulo NREQ.
- Lock:
  - Accepting a command with req_lock=1 makes that requester owner (state LOCKED).
  - In LOCKED, only the owner can be granted. Other requesters see ready=0.
  - Accepting an owner command with lock=0 returns to UNLOCKED after that command.
  - The timeout counter increments on each LOCKED cycle with owner valid=0 and clears when the owner transfers.
  - At LOCK_TIMEOUT, state returns to UNLOCKED. The pointer is unchanged; arbitration resumes next cycle.
- Issue: the accepted command is registered onto the ALSU drives in the next cycle. Any cycle without an accept drives NOP in the following cycle.
  - Shift/rotate therefore operates on the ALSU result of the immediately preceding issue cycle.
  - An idle gap zeroes that result.
- Tag pipeline: LATENCY entries of {valid, id, err}. err = (opcode[2:1]==2'b11). Entries shift every cycle.
- Response: rsp_valid=1 exactly LATENCY cycles after the acceptance cycle, with rsp_id and rsp_err from the tag and rsp_data=alsu_out in that cycle.
  - No response backpressure. Back-to-back accepts give back-to-back responses.
  - rsp_data is passed through unmodified even when rsp_err=1.
- Reset mid-operation: all in-flight tags are discarded, so no rsp_valid is ever produced for commands accepted before rst. The ALSU must share the same rst.
- Simultaneous lock release and another valid requester: the release takes effect the cycle after the lock=0 transfer.

Decomposition:
- Package alsu_ctrl_pkg holds:
  - the command field bit-position constants and the CMD_W=16 constant;
  - opcode constants OP_AND..OP_ROT and OP_INV0/1;
  - the NOP encoding;
  - the arbiter state encoding (UNLOCKED, LOCKED).
- One natural sub-module: rr_arbiter (NREQ, req, lock_mask, pointer -> one-hot grant).

Test Plan:
1. Single ADD: req0 cmd op=010, A=3, B=5, cin=1, accepted at cycle 10 -> rsp_valid at cycle 14 with id=0, data=9, err=0.
2. Contention: after reset, req0 and req1 both valid with 1-cycle ops -> accepts are req0 then req1 on consecutive cycles; responses have id 0 then 1 on consecutive cycles.
3. Locked shift chain: req0 issues bypass_A A=5 lock=1, then op=100 direction=1 serial_in=1 lock=0, back-to-back, while req1 is held valid -> req1 ready=0 for both cycles; results 5 then 11; req1 is granted on the third cycle.
4. Invalid opcode: req1 op=110 -> response with id=1, err=1.
5. Lock timeout: req0 accepted with lock=1, then req0 valid=0 while req1 valid=1 -> req1 ready stays 0 for 8 cycles and asserts on cycle 9.
6. Reset mid-flight: accept an ADD, assert rst for 1 cycle 2 cycles later -> req_ready=0 during rst, no rsp_valid within 10 cycles, and all outputs read 0 after reset.
